ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
Multi-cycle divide/remainder sequencer for the EX stage. It handles the RV64M DIV/DIVU/REM/REMU and the W variants, which the single-cycle ALU leaves unimplemented (ALU DivEn is tied low). It accepts one operation from EX, runs a radix-2 restoring division, and stalls the pipeline until the result is handed back to EX. The result is then muxed onto the EX result path.

Parameters:
XLEN, 64, operand/result width
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
div_valid_i  input  1  EX requests a divide op this cycle
div_sel_i  input  3  op: 000 DIV, 001 DIVU, 010 REM, 011 REMU, 100 DIVW, 101 DIVUW, 110 REMW, 111 REMUW
dividend_i  input  XLEN  src1 (forwarded rs1)
divisor_i  input  XLEN  src2 (forwarded rs2)
flush_i  input  1  pipeline flush (branch/jump redirect)
div_ready_o  output  1  controller idle, can accept
res_valid_o  output  1  result_o valid
res_ready_i  input  1  EX/LS consumes result this cycle
result_o  output  XLEN  quotient or remainder
stall_o  output  1  hold IF/ID/EX pipeline registers

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, res_valid_o=0, result_o=0, internal operand regs=0. div_ready_o=1 combinationally from IDLE.
- States: IDLE, CALC, FIX, DONE. Encoding is free.
- IDLE:
  - Accept when div_valid_i & !flush_i.
  - Latch op, |dividend|, |divisor|, quotient sign (dividend sign XOR divisor sign, signed ops only), remainder sign (dividend sign, signed ops only).
  - W ops use bits [31:0] only: signed W ops sign-extend to 64, unsigned W ops zero-extend, before taking magnitudes.
- Special cases are detected at accept. They go IDLE->DONE directly, so res_valid_o is high one cycle after the accept edge:
  - divisor==0: quotient = all ones (XLEN, or 32 bits sign-extended for W); remainder = dividend (W: low 32 bits sign-extended).
  - Signed overflow (dividend = most negative value, divisor = -1, evaluated at 64 or 32 bits per op): quotient = dividend; remainder = 0. W results are sign-extended from bit 31.
- Normal path: IDLE->CALC with counter = N-1 (N=64, or 32 for W ops).
  - Each CALC cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB on non-negative result.
  - counter==0 in CALC -> FIX. Otherwise decrement.
- FIX (1 cycle):
  - Negate quotient/remainder per the latched signs.
  - Select quotient (DIV*) or remainder (REM*).
  - For all W ops, sign-extend bit 31 to 64 (DIVUW/REMUW included, per ISA).
  - Register into result_o, then go to DONE.
- Latency: res_valid_o rises exactly N+2 cycles after the accept edge (66 for 64-bit ops, 34 for W ops).
- DONE:
  - res_valid_o=1 and result_o held stable.
  - res_ready_i=1 -> IDLE next cycle, res_valid_o=0. result_o keeps its last value.
- stall_o (combinational):
  - 1 in IDLE when div_valid_i & !flush_i.
  - 1 in CALC and FIX.
  - In DONE, stall_o = !res_ready_i.
  - 0 otherwise.
- div_ready_o = (state==IDLE). It is not gated by flush_i.
- flush_i:
  - In any state, next state = IDLE, res_valid_o=0, and no result is produced.
  - Flush in the same cycle as div_valid_i in IDLE: request not accepted.
  - Flush in DONE takes priority over res_ready_i.
- While busy, new div_valid_i is ignored. EX holds the instruction via stall_o.
- Back-to-back ops: a new accept is possible on the cycle the controller is back in IDLE, i.e. one cycle after the DONE handshake.
- Reset mid-operation: immediate return to reset values and no result. The pipeline must not rely on partial results.
- Operand inputs are sampled only at accept. Changes during CALC have no effect.

Test Plan:
- DIVU 100/7 -> accept, stall_o high for 66 cycles, res_valid_o rises at cycle 66, result_o=14. With res_ready_i=1, back to IDLE next cycle.
- REM -100 (0xFFFF_FFFF_FFFF_FF9C) / 7 -> result_o=0xFFFF_FFFF_FFFF_FFFE (-2). DIV of the same operands -> 0xFFFF_FFFF_FFFF_FFF2 (-14).
- Special cases, each with res_valid_o one cycle after accept:
  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REMU 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM of the same operands -> 0.
- DIVW dividend 0x1234_5678_8000_0000 / 1 -> result_o=0xFFFF_FFFF_8000_0000 at latency 34.
- DIVUW 0xFFFF_FFFE / 1 -> 0xFFFF_FFFF_FFFF_FFFE.
- Flush and back-pressure:
  - flush_i pulsed at CALC cycle 10 -> IDLE next cycle, res_valid_o never asserts, stall_o=0.
  - Immediate new DIVU 9/3 -> 3 after 66 cycles.
  - Hold res_ready_i=0 for 5 cycles in DONE -> result_o stable, stall_o=1, then handshake releases.
- Async reset asserted mid-CALC, not aligned to clk -> outputs at reset values immediately. After release, DIV 10/3 -> 3.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle RV64M DIV/DIVU/REM/REMU(+W) sequencer; takes div_valid_i/div_sel_i/dividend_i/divisor_i, holds EX via stall_o, returns result_o over res_valid_o/res_ready_i, div_ready_o when idle, flush_i aborts
module ex_div_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid_i,
  input  logic [2:0]      div_sel_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            div_ready_o,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic op_w, op_rem, q_neg, r_neg;
  logic [XLEN-1:0] rem, quo, dvs;
  logic is_w, is_sgn, d_neg, v_neg, div0, ovf;
  logic [XLEN-1:0] d_sx, dx, vx, da, va, spec_res, rem_nxt, q_fix, r_fix, sel_fix, fix_res;
  logic [XLEN:0] diff;
  always_comb begin
    is_w = div_sel_i[2];
    is_sgn = !div_sel_i[0];
    d_sx = {{(XLEN-32){dividend_i[31]}}, dividend_i[31:0]};
    dx = is_w ? (is_sgn ? d_sx : {{(XLEN-32){1'b0}}, dividend_i[31:0]}) : dividend_i;
    vx = is_w ? (is_sgn ? {{(XLEN-32){divisor_i[31]}}, divisor_i[31:0]} : {{(XLEN-32){1'b0}}, divisor_i[31:0]}) : divisor_i;
    d_neg = is_sgn & dx[XLEN-1];
    v_neg = is_sgn & vx[XLEN-1];
    da = d_neg ? -dx : dx;
    va = v_neg ? -vx : vx;
    div0 = vx == '0;
    ovf = is_sgn && (&vx) && dx == (is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}});
    spec_res = div0 ? (div_sel_i[1] ? (is_w ? d_sx : dividend_i) : '1) : (div_sel_i[1] ? '0 : dx);
    // restoring step: borrow out of the (XLEN+1)-bit trial means the subtraction failed
    diff = {rem, quo[XLEN-1]} - {1'b0, dvs};
    rem_nxt = diff[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : diff[XLEN-1:0];
    q_fix = q_neg ? -quo : quo;
    r_fix = r_neg ? -rem : rem;
    sel_fix = op_rem ? r_fix : q_fix;
    fix_res = op_w ? {{(XLEN-32){sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end
  assign div_ready_o = state == IDLE;
  assign stall_o = state == IDLE ? div_valid_i & !flush_i : state == DONE ? !res_ready_i : 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op_w <= 1'b0;
      op_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      result_o <= '0;
      res_valid_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      res_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_valid_i) begin
          op_w <= is_w;
          op_rem <= div_sel_i[1];
          q_neg <= d_neg ^ v_neg;
          r_neg <= d_neg;
          dvs <= va;
          rem <= '0;
          // W dividends are left-aligned so 32 shifts leave the quotient in the low half
          quo <= is_w ? {da[31:0], {(XLEN-32){1'b0}}} : da;
          cnt <= is_w ? CNT_W'(31) : CNT_W'(XLEN-1);
          if (div0 | ovf) begin
            result_o <= spec_res;
            res_valid_o <= 1'b1;
            state <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[XLEN-2:0], !diff[XLEN]};
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          result_o <= fix_res;
          res_valid_o <= 1'b1;
          state <= DONE;
        end
        DONE: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: self-checking bench for ex_div_ctrl against an arithmetic reference model
module tb_ex_div_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, div_valid = 1'b0, flush = 1'b0, res_ready = 1'b0;
  logic [2:0] sel = '0;
  logic [63:0] dividend = '0, divisor = '0;
  logic div_ready, res_valid, stall;
  logic [63:0] result;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  ex_div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .div_valid_i(div_valid), .div_sel_i(sel),
    .dividend_i(dividend), .divisor_i(divisor), .flush_i(flush),
    .div_ready_o(div_ready), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .result_o(result), .stall_o(stall)
  );
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    if (op[2]) begin
      if (ub32 == 0) r32 = op[1] ? ua32 : 32'hFFFF_FFFF;
      else if (!op[0] && ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : ua32;
      else if (!op[0]) r32 = op[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      else r32 = op[1] ? ua32 % ub32 : ua32 / ub32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 0) r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = op[1] ? 64'd0 : a;
      else if (!op[0]) r = op[1] ? 64'(sa % sb) : 64'(sa / sb);
      else r = op[1] ? a % b : a / b;
    end
    return r;
  endfunction
  function automatic int exp_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sp;
    sp = op[2] ? (b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF))
               : (b == 0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return sp ? 1 : (op[2] ? 34 : 66);
  endfunction
  task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output logic acc_stall);
    sel = op; dividend = a; divisor = b; div_valid = 1'b1;
    #1 acc_stall = stall;
    @(negedge clk);
    div_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
  endtask
  task automatic wait_valid(output int lat, output int stalls);
    lat = 1; stalls = 0;
    while (!res_valid && lat < 200) begin
      stalls += int'(stall);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic handshake;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", res_valid); else n_pass++;
    n_total++; if (result !== 64'd0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
    n_total++; if (div_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", div_ready); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_divu;
    logic s; int lat, st;
    start_op(3'b001, 64'd100, 64'd7, s);
    wait_valid(lat, st);
    n_total++; if (lat !== 66) $display("FAIL divu_latency: got %0d expected 66", lat); else n_pass++;
    n_total++; if (int'(s) + st !== 66) $display("FAIL divu_stall_cycles: got %0d expected 66", int'(s) + st); else n_pass++;
    n_total++; if (result !== 64'd14) $display("FAIL divu_result: got %h expected %h", result, 64'd14); else n_pass++;
    res_ready = 1'b1;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL divu_done_stall: got %b expected 0", stall); else n_pass++;
    @(negedge clk);
    res_ready = 1'b0;
    n_total++; if ({res_valid, div_ready} !== 2'b01) $display("FAIL divu_release: got valid/ready %b expected 01", {res_valid, div_ready}); else n_pass++;
    n_total++; if (result !== 64'd14) $display("FAIL divu_result_kept: got %h expected %h", result, 64'd14); else n_pass++;
  endtask
  task automatic test_signed;
    logic [2:0] ops [2] = '{3'b010, 3'b000};
    logic [63:0] exps [2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2};
    logic s; int lat, st;
    for (int i = 0; i < 2; i++) begin
      start_op(ops[i], 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, s);
      wait_valid(lat, st);
      n_total++; if (result !== exps[i]) $display("FAIL signed_result[%0d]: got %h expected %h", i, result, exps[i]); else n_pass++;
      n_total++; if (lat !== 66) $display("FAIL signed_latency[%0d]: got %0d expected 66", i, lat); else n_pass++;
      handshake();
    end
  endtask
  task automatic test_special;
    logic [2:0] ops [4] = '{3'b000, 3'b011, 3'b000, 3'b010};
    logic [63:0] as [4] = '{64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] bs [4] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] exps [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
    logic s; int lat, st;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i], s);
      wait_valid(lat, st);
      n_total++; if (lat !== 1) $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); else n_pass++;
      n_total++; if (result !== exps[i]) $display("FAIL special_result[%0d]: got %h expected %h", i, result, exps[i]); else n_pass++;
      handshake();
    end
  endtask
  task automatic test_word;
    logic [2:0] ops [2] = '{3'b100, 3'b101};
    logic [63:0] as [2] = '{64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFE};
    logic [63:0] exps [2] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFE};
    logic s; int lat, st;
    for (int i = 0; i < 2; i++) begin
      start_op(ops[i], as[i], 64'd1, s);
      wait_valid(lat, st);
      n_total++; if (lat !== 34) $display("FAIL word_latency[%0d]: got %0d expected 34", i, lat); else n_pass++;
      n_total++; if (result !== exps[i]) $display("FAIL word_result[%0d]: got %h expected %h", i, result, exps[i]); else n_pass++;
      handshake();
    end
  endtask
  task automatic test_flush;
    logic s; int lat, st;
    start_op(3'b001, 64'd1000, 64'd7, s);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++; if ({div_ready, stall, res_valid} !== 3'b100) $display("FAIL flush_calc: got ready/stall/valid %b expected 100", {div_ready, stall, res_valid}); else n_pass++;
    start_op(3'b001, 64'd9, 64'd3, s);
    wait_valid(lat, st);
    n_total++; if (lat !== 66) $display("FAIL flush_next_latency: got %0d expected 66", lat); else n_pass++;
    n_total++; if (result !== 64'd3) $display("FAIL flush_next_result: got %h expected %h", result, 64'd3); else n_pass++;
    handshake();
    sel = 3'b000; dividend = 64'd5; divisor = 64'd0; div_valid = 1'b1; flush = 1'b1;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL flush_accept_stall: got %b expected 0", stall); else n_pass++;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    n_total++; if ({res_valid, div_ready} !== 2'b01) $display("FAIL flush_accept_blocked: got valid/ready %b expected 01", {res_valid, div_ready}); else n_pass++;
    start_op(3'b000, 64'd5, 64'd0, s);
    n_total++; if (res_valid !== 1'b1) $display("FAIL flush_done_pre: got %b expected 1", res_valid); else n_pass++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++; if ({res_valid, div_ready} !== 2'b01) $display("FAIL flush_done: got valid/ready %b expected 01", {res_valid, div_ready}); else n_pass++;
  endtask
  task automatic test_backpressure;
    logic s; int lat, st;
    logic [63:0] r0;
    start_op(3'b000, 64'd1234, 64'd10, s);
    wait_valid(lat, st);
    r0 = result;
    n_total++; if (r0 !== 64'd123) $display("FAIL bp_result: got %h expected %h", r0, 64'd123); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++; if ({res_valid, stall, result} !== {1'b1, 1'b1, 64'd123}) $display("FAIL bp_hold[%0d]: got valid/stall/result %b/%b/%h expected 1/1/%h", i, res_valid, stall, result, 64'd123); else n_pass++;
    end
    handshake();
    n_total++; if (res_valid !== 1'b0) $display("FAIL bp_release: got %b expected 0", res_valid); else n_pass++;
  endtask
  task automatic test_back_to_back;
    logic s; int lat, st;
    start_op(3'b001, 64'd77, 64'd7, s);
    wait_valid(lat, st);
    n_total++; if (result !== 64'd11) $display("FAIL b2b_first: got %h expected %h", result, 64'd11); else n_pass++;
    handshake();
    n_total++; if (div_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", div_ready); else n_pass++;
    start_op(3'b011, 64'd77, 64'd10, s);
    wait_valid(lat, st);
    n_total++; if (lat !== 66) $display("FAIL b2b_latency: got %0d expected 66", lat); else n_pass++;
    n_total++; if (result !== 64'd7) $display("FAIL b2b_second: got %h expected %h", result, 64'd7); else n_pass++;
    handshake();
  endtask
  task automatic test_async_reset;
    logic s; int lat, st;
    start_op(3'b000, 64'd1000, 64'd3, s);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({res_valid, div_ready, stall} !== 3'b010) $display("FAIL arst_ctrl: got valid/ready/stall %b expected 010", {res_valid, div_ready, stall}); else n_pass++;
    n_total++; if (result !== 64'd0) $display("FAIL arst_result: got %h expected 0", result); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(3'b000, 64'd10, 64'd3, s);
    wait_valid(lat, st);
    n_total++; if (lat !== 66) $display("FAIL arst_after_latency: got %0d expected 66", lat); else n_pass++;
    n_total++; if (result !== 64'd3) $display("FAIL arst_after_result: got %h expected %h", result, 64'd3); else n_pass++;
    handshake();
  endtask
  task automatic test_random;
    logic s; int lat, st, elat;
    logic [2:0] op;
    logic [63:0] a, b, exp_r;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: begin
          a = op[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = op[2] ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      exp_r = model(op, a, b);
      elat = exp_lat(op, a, b);
      start_op(op, a, b, s);
      wait_valid(lat, st);
      n_total++; if (result !== exp_r) $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, result, exp_r); else n_pass++;
      n_total++; if (lat !== elat) $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, op, lat, elat); else n_pass++;
      handshake();
    end
  endtask
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_special();
    test_word();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
